// File: rtl/gate_bist.sv
// rtl/gate_bist.sv - BIST sequencer that sweeps every input vector of a gate and checks gate_y against TRUTH
// Optional macro GATE_BIST_STOP_ON_FAIL_EN: end the run at the first mismatch, leaving stim on the failing vector.
module gate_bist #(
    parameter int                  N_IN   = 2,
    parameter int                  SETTLE = 2,
    parameter logic [2**N_IN-1:0]  TRUTH  = 4'b0111
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            gate_y,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_vec
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPLY  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int              CW       = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};
    localparam logic [N_IN:0]   ERR_MAX  = (N_IN + 1)'(2 ** N_IN);

    logic [2:0]      state_q, state_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] fv_q, fv_d;
    logic            mismatch;

    assign mismatch = (gate_y != TRUTH[stim_q]);

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_APPLY;
                    stim_d  = '0;
                    err_d   = '0;
                    fv_d    = '0;
                end
            end
            S_APPLY: begin
                cnt_d   = CW'(SETTLE);
                state_d = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
            end
            S_WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                    if (err_q == '0)      fv_d  = stim_q;
                end
`ifdef GATE_BIST_STOP_ON_FAIL_EN
                // Failing vector stays on stim so the gate can be probed in DONE.
                if (mismatch) begin
                    state_d = S_DONE;
                end else if (stim_q == LAST_VEC) begin
                    state_d = S_DONE;
                    stim_d  = '0;
                end else begin
                    state_d = S_APPLY;
                    stim_d  = stim_q + 1'b1;
                end
`else
                if (stim_q == LAST_VEC) begin
                    state_d = S_DONE;
                    stim_d  = '0;
                end else begin
                    state_d = S_APPLY;
                    stim_d  = stim_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stim_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fv_q    <= '0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
        end
    end

    assign stim      = stim_q;
    assign busy      = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_SAMPLE);
    assign done      = (state_q == S_DONE);
    assign pass      = done && (err_q == '0);
    assign err_count = err_q;
    assign fail_vec  = fv_q;

endmodule

// File: tb/tb_gate_bist.sv
// tb/tb_gate_bist.sv - self-checking bench for gate_bist (SETTLE=2 and SETTLE=0 instances side by side)
module tb_gate_bist;

    localparam logic [3:0] TRUTH = 4'b0111;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    int         gmode = 0;
    int         n_tests = 0;
    int         n_fail  = 0;

    logic [1:0] d_stim [2];
    logic [1:0] d_fv   [2];
    logic [2:0] d_err  [2];
    logic       d_busy [2];
    logic       d_done [2];
    logic       d_pass [2];
    logic       d_gy   [2];

    always #5 clk = ~clk;

    // Gate models: 0 NAND, 1 stuck-at-1, 2 AND, 3 stuck-at-0
    function automatic logic gate_fn(input int mode, input logic [1:0] v);
        case (mode)
            0:       return !(v[1] & v[0]);
            1:       return 1'b1;
            2:       return v[1] & v[0];
            default: return 1'b0;
        endcase
    endfunction

    assign d_gy[0] = gate_fn(gmode, d_stim[0]);
    assign d_gy[1] = gate_fn(gmode, d_stim[1]);

    gate_bist #(.N_IN(2), .SETTLE(2), .TRUTH(4'b0111)) u_s2 (
        .clk(clk), .rst_n(rst_n), .start(start), .gate_y(d_gy[0]),
        .stim(d_stim[0]), .busy(d_busy[0]), .done(d_done[0]), .pass(d_pass[0]),
        .err_count(d_err[0]), .fail_vec(d_fv[0])
    );

    gate_bist #(.N_IN(2), .SETTLE(0), .TRUTH(4'b0111)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start), .gate_y(d_gy[1]),
        .stim(d_stim[1]), .busy(d_busy[1]), .done(d_done[1]), .pass(d_pass[1]),
        .err_count(d_err[1]), .fail_vec(d_fv[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: position in the run is a cycle count k since the start edge
    int m_k    [2];
    bit m_run  [2];
    bit m_done [2];
    int m_mode [2];

    function automatic int per(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic bit mism(input int mode, input int v);
        logic [1:0] vv;
        vv = v[1:0];
        return gate_fn(mode, vv) != TRUTH[v];
    endfunction

    function automatic int first_fail(input int mode);
        for (int v = 0; v < 4; v++) if (mism(mode, v)) return v;
        return -1;
    endfunction

    function automatic int run_len(input int i);
        int ff;
        ff = first_fail(m_mode[i]);
        return (STOP && ff >= 0) ? (ff + 1) * per(i) : 4 * per(i);
    endfunction

    function automatic int err_at(input int i, input int k);
        int n;
        n = 0;
        for (int v = 0; v < 4; v++) if (mism(m_mode[i], v) && (v + 1) * per(i) <= k) n++;
        return n;
    endfunction

    function automatic int fv_at(input int i, input int k);
        for (int v = 0; v < 4; v++) if (mism(m_mode[i], v) && (v + 1) * per(i) <= k) return v;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_run[i]  <= 1'b0;
                m_done[i] <= 1'b0;
                m_k[i]    <= 0;
            end else if (m_run[i]) begin
                m_k[i] <= m_k[i] + 1;
                if (m_k[i] + 1 == run_len(i)) begin
                    m_run[i]  <= 1'b0;
                    m_done[i] <= 1'b1;
                end
            end else if (start) begin
                m_run[i]  <= 1'b1;
                m_done[i] <= 1'b0;
                m_k[i]    <= 0;
                m_mode[i] <= gmode;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int e_err, e_fv, e_stim, ff;
            ff     = first_fail(m_mode[i]);
            e_err  = (m_run[i] || m_done[i]) ? err_at(i, m_k[i]) : 0;
            e_fv   = (m_run[i] || m_done[i]) ? fv_at(i, m_k[i]) : 0;
            e_stim = m_run[i] ? m_k[i] / per(i) :
                     (m_done[i] && STOP && ff >= 0) ? ff : 0;
            chk($sformatf("s%0d_busy", i), int'(d_busy[i]), int'(m_run[i]));
            chk($sformatf("s%0d_done", i), int'(d_done[i]), int'(m_done[i]));
            chk($sformatf("s%0d_pass", i), int'(d_pass[i]), int'(m_done[i] && e_err == 0));
            chk($sformatf("s%0d_err",  i), int'(d_err[i]),  e_err);
            chk($sformatf("s%0d_fv",   i), int'(d_fv[i]),   e_fv);
            chk($sformatf("s%0d_stim", i), int'(d_stim[i]), e_stim);
        end
    end

    task automatic do_run(input int mode, input int mid, output int c2, output int c0);
        gmode = mode;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        c2 = -1;
        c0 = -1;
        for (int c = 1; c <= 60 && c2 < 0; c++) begin
            @(posedge clk);
            #1;
            start = (c == mid);
            if (d_done[1] && c0 < 0) c0 = c;
            if (d_done[0] && c2 < 0) c2 = c;
        end
        start = 1'b0;
    endtask

    task automatic check_res(input string nm, input int c2, input int c0, input int e_c2, input int e_c0,
                             input int e_err, input int e_fv, input int e_pass, input int e_stim);
        chk({nm, "_cyc_s2"}, c2, e_c2);
        chk({nm, "_cyc_s0"}, c0, e_c0);
        chk({nm, "_err"},  int'(d_err[0]),  e_err);
        chk({nm, "_fv"},   int'(d_fv[0]),   e_fv);
        chk({nm, "_pass"}, int'(d_pass[0]), e_pass);
        chk({nm, "_stim"}, int'(d_stim[0]), e_stim);
    endtask

    initial begin
        int c2, c0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(d_busy[0]), 0);
        chk("rst_done", int'(d_done[0]), 0);
        chk("rst_err",  int'(d_err[0]),  0);
        @(negedge clk);
        rst_n = 1'b1;

        do_run(0, -1, c2, c0);
        check_res("nand", c2, c0, 16, 8, 0, 0, 1, 0);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        do_run(1, -1, c2, c0);
        check_res("stuck1", c2, c0, 16, 8, 1, 3, 0, 3);
        do_run(2, -1, c2, c0);
        check_res("and", c2, c0, 4, 2, 1, 0, 0, 0);
        do_run(3, -1, c2, c0);
        check_res("stuck0", c2, c0, 4, 2, 1, 0, 0, 0);
        repeat (4) @(posedge clk);
`else
        do_run(1, -1, c2, c0);
        check_res("stuck1", c2, c0, 16, 8, 1, 3, 0, 0);
        do_run(2, -1, c2, c0);
        check_res("and", c2, c0, 16, 8, 4, 0, 0, 0);
        do_run(3, -1, c2, c0);
        check_res("stuck0", c2, c0, 16, 8, 3, 0, 0, 0);
`endif

        do_run(0, 4, c2, c0);
        check_res("midstart", c2, c0, 16, 8, 0, 0, 1, 0);

        do_run(1, 15, c2, c0);
        chk("lastsample_cyc", c2, 16);
        repeat (2) @(posedge clk);
        #1;
        chk("lastsample_done", int'(d_done[0]), 1);
        chk("lastsample_err",  int'(d_err[0]),  1);
        repeat (12) @(posedge clk);

        gmode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre_rst_busy", int'(d_busy[0]), 1);
        chk("pre_rst_stim", int'(d_stim[0]), 2);
        #1 rst_n = 1'b0;
        #1;
        chk("async_busy", int'(d_busy[0]), 0);
        chk("async_stim", int'(d_stim[0]), 0);
        chk("async_err",  int'(d_err[0]),  0);
        chk("async_fv",   int'(d_fv[0]),   0);
        chk("async_done", int'(d_done[1]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_run(0, -1, c2, c0);
        check_res("after_rst", c2, c0, 16, 8, 0, 0, 1, 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
